// File: rtl/univ_reg_sync.sv
// -----------------------------------------------------------------------------
// univ_reg_sync
//
// Parametrised N-bit universal register. It generalises a D flip-flop with
// synchronous set/reset into a storage, shift, rotate and up/down count element.
//
// Parameters
//   WIDTH        register width in bits (>= 2)
//   RESET_VALUE  value loaded into q on reset
//
// Ports
//   clk    in   1      clock; all state changes on its rising edge
//   reset  in   1      synchronous active-high reset (highest priority)
//   set    in   1      synchronous active-high set, q <= all ones
//   en     in   1      operation enable; 0 holds q and co
//   mode   in   3      operation select (see MODE_* below)
//   d      in   WIDTH  parallel load data
//   sin_r  in   1      serial input entering bit 0 on shift-left
//   sin_l  in   1      serial input entering bit WIDTH-1 on shift-right
//   q      out  WIDTH  register contents
//   co     out  1      registered carry / borrow / shifted-out bit
//   zero   out  1      combinational, 1 when q == 0
// -----------------------------------------------------------------------------
module univ_reg_sync #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;

    // Next state for everything except reset; reset is applied in the
    // register process so it overrides set and en unconditionally.
    always_comb begin
        q_d  = q_q;
        co_d = co_q;
        if (set) begin
            q_d  = ALL_ONES;
            co_d = 1'b0;
        end else if (en) begin
            unique case (mode)
                MODE_HOLD: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
                MODE_LOAD: begin
                    q_d  = d;
                    co_d = 1'b0;
                end
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], sin_r};
                    co_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d  = {sin_l, q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    co_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                MODE_INC: begin
                    // Carry only on wrap from all ones to zero.
                    q_d  = q_q + ONE;
                    co_d = (q_q == ALL_ONES);
                end
                MODE_DEC: begin
                    // Borrow only on wrap from zero to all ones.
                    q_d  = q_q - ONE;
                    co_d = (q_q == {WIDTH{1'b0}});
                end
                default: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= RESET_VALUE;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            co_q <= co_d;
        end
    end

    assign q    = q_q;
    assign co   = co_q;
    assign zero = (q_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_univ_reg_sync.sv
// -----------------------------------------------------------------------------
// tb_univ_reg_sync
//
// Self-checking bench for univ_reg_sync. Two instances: an 8-bit register with
// RESET_VALUE 8'hA5 and a 2-bit register with RESET_VALUE 0. Each test task
// walks a table of stimulus, pushes the expected {zero, co, q} onto a queue as
// the stimulus is driven, then pops and compares after the clock edge.
// -----------------------------------------------------------------------------
module tb_univ_reg_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance signals
    logic       r8, s8, e8, sr8, sl8;
    logic [2:0] m8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       co8, z8;

    // 2-bit instance signals
    logic       r2, s2, e2, sr2, sl2;
    logic [2:0] m2;
    logic [1:0] d2;
    logic [1:0] q2;
    logic       co2, z2;

    univ_reg_sync #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk(clk), .reset(r8), .set(s8), .en(e8), .mode(m8), .d(d8),
        .sin_r(sr8), .sin_l(sl8), .q(q8), .co(co8), .zero(z8)
    );

    univ_reg_sync #(.WIDTH(2), .RESET_VALUE(2'b00)) dut2 (
        .clk(clk), .reset(r2), .set(s2), .en(e2), .mode(m2), .d(d2),
        .sin_r(sr2), .sin_l(sl2), .q(q2), .co(co2), .zero(z2)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboards: expected {zero, co, q}
    logic [9:0] exp_q[$];
    logic [3:0] exp2_q[$];

    typedef struct packed {
        logic       r, s, e;
        logic [2:0] m;
        logic [7:0] d;
        logic       sr, sl;
        logic [9:0] exp;
    } vec8_t;

    typedef struct packed {
        logic       r, s, e;
        logic [2:0] m;
        logic [1:0] d;
        logic [3:0] exp;
    } vec2_t;

    function automatic vec8_t mk8(input logic r, s, e, input logic [2:0] m,
                                  input logic [7:0] d, input logic sr, sl,
                                  input logic [7:0] eq, input logic eco);
        vec8_t v;
        v.r = r; v.s = s; v.e = e; v.m = m; v.d = d; v.sr = sr; v.sl = sl;
        v.exp = {(eq == 8'h00), eco, eq};
        return v;
    endfunction

    function automatic vec2_t mk2(input logic r, s, e, input logic [2:0] m,
                                  input logic [1:0] d,
                                  input logic [1:0] eq, input logic eco);
        vec2_t v;
        v.r = r; v.s = s; v.e = e; v.m = m; v.d = d;
        v.exp = {(eq == 2'b00), eco, eq};
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive8(input vec8_t v);
        r8 = v.r; s8 = v.s; e8 = v.e; m8 = v.m; d8 = v.d; sr8 = v.sr; sl8 = v.sl;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input vec2_t v);
        r2 = v.r; s2 = v.s; e2 = v.e; m2 = v.m; d2 = v.d; sr2 = 1'b0; sl2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        vec8_t tbl[2];
        logic [9:0] want;
        // reset and set together with a load pending: reset wins
        tbl[0] = mk8(1, 1, 1, 3'b001, 8'h3C, 0, 0, 8'hA5, 0);
        tbl[1] = mk8(0, 1, 0, 3'b000, 8'h00, 0, 0, 8'hFF, 0);
        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i].exp);
            drive8(tbl[i]);
            want = exp_q.pop_front();
            checks++;
            if ({z8, co8, q8} !== want) begin
                errors++;
                $display("FAIL reset[%0d]: got zero=%b co=%b q=%h, expected zero=%b co=%b q=%h",
                         i, z8, co8, q8, want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_load_hold;
        vec8_t tbl[5];
        logic [9:0] want;
        tbl[0] = mk8(0, 0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0);
        tbl[1] = mk8(0, 0, 0, 3'b110, 8'h00, 1, 1, 8'h81, 0);
        tbl[2] = mk8(0, 0, 0, 3'b110, 8'h55, 1, 1, 8'h81, 0);
        tbl[3] = mk8(0, 0, 0, 3'b110, 8'hAA, 1, 1, 8'h81, 0);
        tbl[4] = mk8(0, 0, 1, 3'b000, 8'h3C, 1, 1, 8'h81, 0);
        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i].exp);
            drive8(tbl[i]);
            want = exp_q.pop_front();
            checks++;
            if ({z8, co8, q8} !== want) begin
                errors++;
                $display("FAIL load_hold[%0d]: got zero=%b co=%b q=%h, expected zero=%b co=%b q=%h",
                         i, z8, co8, q8, want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_shifts;
        vec8_t tbl[9];
        logic [9:0] want;
        // d is driven unknown throughout: shift/rotate must not depend on it
        tbl[0] = mk8(0, 0, 1, 3'b010, 8'hxx, 0, 1'bx, 8'h02, 1); // SHL sin_r=0
        tbl[1] = mk8(0, 0, 0, 3'b111, 8'hxx, 0, 0,    8'h02, 1); // en=0 keeps co
        tbl[2] = mk8(0, 0, 1, 3'b000, 8'hxx, 0, 0,    8'h02, 1); // hold keeps co
        tbl[3] = mk8(0, 0, 1, 3'b011, 8'hxx, 1'bx, 1, 8'h81, 0); // SHR sin_l=1
        tbl[4] = mk8(0, 0, 1, 3'b101, 8'hxx, 1'bx, 1'bx, 8'hC0, 1); // ROR
        tbl[5] = mk8(0, 0, 1, 3'b100, 8'hxx, 1'bx, 1'bx, 8'h81, 1); // ROL
        tbl[6] = mk8(0, 0, 1, 3'b010, 8'hxx, 1, 1'bx, 8'h03, 1);    // SHL sin_r=1
        tbl[7] = mk8(0, 0, 1, 3'b011, 8'hxx, 1'bx, 0, 8'h01, 1);    // SHR sin_l=0
        tbl[8] = mk8(0, 0, 1, 3'b011, 8'hxx, 1'bx, 0, 8'h00, 1);    // SHR to zero
        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i].exp);
            drive8(tbl[i]);
            want = exp_q.pop_front();
            checks++;
            if ({z8, co8, q8} !== want) begin
                errors++;
                $display("FAIL shifts[%0d]: got zero=%b co=%b q=%h, expected zero=%b co=%b q=%h",
                         i, z8, co8, q8, want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_count_wrap;
        vec8_t tbl[5];
        logic [9:0] want;
        tbl[0] = mk8(0, 0, 1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0);
        tbl[1] = mk8(0, 0, 1, 3'b110, 8'hxx, 1'bx, 1'bx, 8'hFF, 0);
        tbl[2] = mk8(0, 0, 1, 3'b110, 8'hxx, 1'bx, 1'bx, 8'h00, 1);
        tbl[3] = mk8(0, 0, 1, 3'b111, 8'hxx, 1'bx, 1'bx, 8'hFF, 1);
        tbl[4] = mk8(0, 0, 1, 3'b111, 8'hxx, 1'bx, 1'bx, 8'hFE, 0);
        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i].exp);
            drive8(tbl[i]);
            want = exp_q.pop_front();
            checks++;
            if ({z8, co8, q8} !== want) begin
                errors++;
                $display("FAIL count_wrap[%0d]: got zero=%b co=%b q=%h, expected zero=%b co=%b q=%h",
                         i, z8, co8, q8, want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        vec8_t tbl[7];
        logic [9:0] want;
        tbl[0] = mk8(0, 0, 1, 3'b001, 8'h10, 0, 0, 8'h10, 0);
        tbl[1] = mk8(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'h11, 0);
        tbl[2] = mk8(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'h12, 0);
        tbl[3] = mk8(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'h13, 0);
        tbl[4] = mk8(1, 0, 1, 3'b110, 8'h00, 0, 0, 8'hA5, 0);
        tbl[5] = mk8(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'hA6, 0);
        tbl[6] = mk8(0, 1, 1, 3'b110, 8'h00, 0, 0, 8'hFF, 0); // set beats count
        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i].exp);
            drive8(tbl[i]);
            want = exp_q.pop_front();
            checks++;
            if ({z8, co8, q8} !== want) begin
                errors++;
                $display("FAIL reset_mid_count[%0d]: got zero=%b co=%b q=%h, expected zero=%b co=%b q=%h",
                         i, z8, co8, q8, want[9], want[8], want[7:0]);
            end
        end
    endtask

    // Random operations against a small behavioural model of the register.
    task automatic test_random;
        logic [7:0] mq;
        logic       mco;
        vec8_t      v;
        logic [9:0] want;
        mq  = 8'hA5;
        mco = 1'b0;
        for (int n = 0; n < 60; n++) begin
            v.r  = (n == 0) || ($urandom_range(0, 19) == 0);
            v.s  = ($urandom_range(0, 14) == 0);
            v.e  = ($urandom_range(0, 4) != 0);
            v.m  = 3'($urandom_range(0, 7));
            v.d  = 8'($urandom_range(0, 255));
            v.sr = 1'($urandom_range(0, 1));
            v.sl = 1'($urandom_range(0, 1));
            if (v.r) begin
                mq = 8'hA5; mco = 1'b0;
            end else if (v.s) begin
                mq = 8'hFF; mco = 1'b0;
            end else if (v.e) begin
                case (v.m)
                    3'd1: begin mq = v.d; mco = 1'b0; end
                    3'd2: begin mco = mq[7]; mq = mq << 1; mq[0] = v.sr; end
                    3'd3: begin mco = mq[0]; mq = mq >> 1; mq[7] = v.sl; end
                    3'd4: begin mco = mq[7]; mq = (mq << 1) | (mq >> 7); end
                    3'd5: begin mco = mq[0]; mq = (mq >> 1) | (mq << 7); end
                    3'd6: begin mco = (mq == 8'd255); mq = 8'((int'(mq) + 1) % 256); end
                    3'd7: begin mco = (mq == 8'd0);   mq = 8'((int'(mq) + 255) % 256); end
                    default: ;
                endcase
            end
            v.exp = {(mq == 8'h00), mco, mq};
            exp_q.push_back(v.exp);
            drive8(v);
            want = exp_q.pop_front();
            checks++;
            if ({z8, co8, q8} !== want) begin
                errors++;
                $display("FAIL random[%0d] mode=%0d: got zero=%b co=%b q=%h, expected zero=%b co=%b q=%h",
                         n, v.m, z8, co8, q8, want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_width2;
        vec2_t tbl[8];
        logic [3:0] want;
        tbl[0] = mk2(1, 0, 0, 3'b000, 2'b00, 2'b00, 0); // reset, zero=1
        tbl[1] = mk2(0, 0, 1, 3'b001, 2'b10, 2'b10, 0);
        tbl[2] = mk2(0, 0, 1, 3'b110, 2'b00, 2'b11, 0);
        tbl[3] = mk2(0, 0, 1, 3'b110, 2'b00, 2'b00, 1);
        tbl[4] = mk2(0, 0, 1, 3'b110, 2'b00, 2'b01, 0);
        tbl[5] = mk2(0, 0, 1, 3'b001, 2'b10, 2'b10, 0);
        tbl[6] = mk2(0, 0, 1, 3'b100, 2'b00, 2'b01, 1);
        tbl[7] = mk2(0, 0, 1, 3'b111, 2'b00, 2'b00, 0);
        foreach (tbl[i]) begin
            exp2_q.push_back(tbl[i].exp);
            drive2(tbl[i]);
            want = exp2_q.pop_front();
            checks++;
            if ({z2, co2, q2} !== want) begin
                errors++;
                $display("FAIL width2[%0d]: got zero=%b co=%b q=%b, expected zero=%b co=%b q=%b",
                         i, z2, co2, q2, want[3], want[2], want[1:0]);
            end
        end
    endtask

    initial begin
        r8 = 1'b0; s8 = 1'b0; e8 = 1'b0; m8 = 3'b000; d8 = 8'h00; sr8 = 1'b0; sl8 = 1'b0;
        r2 = 1'b1; s2 = 1'b0; e2 = 1'b0; m2 = 3'b000; d2 = 2'b00; sr2 = 1'b0; sl2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_hold();
        test_shifts();
        test_count_wrap();
        test_reset_mid_count();
        test_random();
        test_width2();
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0",
                     exp_q.size(), exp2_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
